dplca_node_ctrl: RTL and testbench

- Synthesizable, clocked, parametrised successor to the behavioural DPLCA node-role state machine (Clause 148 dynamic PLCA).
- Decides coordinator/follower role, maintains plca_node_count, and picks a local transmit-opportunity ID (local_nodeID) from the TXOP claim table.
- Sits between the PLCA control/status machines and the DPLCA claim-table/aging logic.
- New versus the previous generation: generic node count and ID width, internal wait-beacon timer, registered outputs, a sequential free-TXOP search, and saturating node-count arithmetic.

---
 rtl/dplca_pkg.sv | 39 +++
 rtl/dplca_claim_decode.sv | 50 +++++
 rtl/dplca_node_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_dplca_node_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dplca_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : dplca_pkg
// Description : Shared encodings for the DPLCA node-role controller.
// Revision    : 1.0
//----------------------------------------------------------------------------
package dplca_pkg;

  typedef enum logic [3:0] {
    ST_DISABLED            = 4'd0,
    ST_WAIT_BEACON         = 4'd1,
    ST_COORDINATOR         = 4'd2,
    ST_REDUCE_NODE_COUNT   = 4'd3,
    ST_INCREASE_NODE_COUNT = 4'd4,
    ST_LEARNING            = 4'd5,
    ST_FOLLOWER            = 4'd6,
    ST_FOLLOWER_SCAN       = 4'd7,
    ST_LOOPBACK            = 4'd8
  } dplca_state_e;

  typedef enum logic [1:0] {
    CLAIM_FREE = 2'b00,
    CLAIM_SOFT = 2'b01,
    CLAIM_HARD = 2'b10
  } claim_e;

  typedef enum logic [1:0] {
    CMD_BEACON = 2'b00,
    CMD_COMMIT = 2'b01,
    CMD_NONE   = 2'b10
  } cmd_e;

  typedef enum logic {
    STATUS_FAIL = 1'b0,
    STATUS_OK   = 1'b1
  } status_e;

endpackage
`default_nettype wire

// File: rtl/dplca_claim_decode.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : dplca_claim_decode
// Description : Combinational TXOP claim-table lookups and highest HARD claim.
// Revision    : 1.0
//----------------------------------------------------------------------------
module dplca_claim_decode
  import dplca_pkg::*;
#(
  parameter int MAX_NODES = 256,
  parameter int ID_W      = 8
) (
  input  logic [2*MAX_NODES-1:0] txop_claim_table,
  input  logic [ID_W-1:0]        cnt_m1_idx,
  input  logic [ID_W-1:0]        local_idx,
  input  logic [ID_W-1:0]        scan_idx,
  output logic [ID_W-1:0]        max_hard_claim,
  output logic                   hard_at_zero,
  output logic                   hard_at_cnt_m1,
  output logic                   hard_at_local,
  output logic                   soft_at_local,
  output logic                   free_at_scan
);

  logic [MAX_NODES-1:0] w_hard;
  logic [MAX_NODES-1:0] w_soft;
  logic [MAX_NODES-1:0] w_free;

  // Code 11 has the upper bit set and therefore counts as HARD.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_entry
    assign w_hard[gi] = txop_claim_table[2*gi+1];
    assign w_soft[gi] = (txop_claim_table[2*gi +: 2] == CLAIM_SOFT);
    assign w_free[gi] = (txop_claim_table[2*gi +: 2] == CLAIM_FREE);
  end

  always_comb begin
    max_hard_claim = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (w_hard[i]) max_hard_claim = ID_W'(i);
    end
  end

  assign hard_at_zero   = w_hard[0];
  assign hard_at_cnt_m1 = w_hard[cnt_m1_idx];
  assign hard_at_local  = w_hard[local_idx];
  assign soft_at_local  = w_soft[local_idx];
  assign free_at_scan   = w_free[scan_idx];

endmodule
`default_nettype wire

// File: rtl/dplca_node_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : dplca_node_ctrl
// Description : DPLCA coordinator/follower role, node count and local TXOP ID.
//               Optional own-beacon loopback state: DPLCA_LOOPBACK_EN.
// Revision    : 1.0
//----------------------------------------------------------------------------
module dplca_node_ctrl
  import dplca_pkg::*;
#(
  parameter int MAX_NODES          = 256,
  parameter int ID_W               = 8,
  parameter int MIN_NODE_COUNT     = 8,
  parameter int WAIT_BEACON_CYCLES = 4000
) (
  input  logic                   clk,
  input  logic                   plca_reset,
  input  logic                   dplca_en,
  input  logic                   plca_en,
  input  logic                   coordinator_role_allowed,
  input  logic                   plca_status,
  input  logic [1:0]             rx_cmd,
  input  logic [1:0]             tx_cmd,
  input  logic                   CRS,
  input  logic                   COL,
  input  logic                   plca_tx_beacon,
  input  logic                   dplca_txop_table_upd,
  input  logic                   dplca_new_age,
  input  logic [ID_W-1:0]        dplca_txop_id,
  input  logic [ID_W-1:0]        dplca_txop_node_count,
  input  logic [2*MAX_NODES-1:0] txop_claim_table,
  output logic [ID_W-1:0]        local_nodeID,
  output logic [ID_W-1:0]        plca_node_count,
  output logic                   dplca_aging,
  output logic                   node_id_valid,
  output logic [3:0]             dplca_state
);

  localparam int                c_tmr_w    = (WAIT_BEACON_CYCLES > 2) ? $clog2(WAIT_BEACON_CYCLES) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_load = c_tmr_w'(WAIT_BEACON_CYCLES - 1);
  localparam logic [ID_W-1:0]    c_id_max   = ID_W'(MAX_NODES - 1);
  localparam logic [ID_W-1:0]    c_cnt_min  = ID_W'(MIN_NODE_COUNT);

  dplca_state_e       r_state, w_state_nxt;
  logic [c_tmr_w-1:0] r_tmr;
  logic [ID_W-1:0]    r_local_id, w_id_nxt;
  logic [ID_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]    r_scan_idx, w_scan_nxt;
  logic               r_aging, w_aging_nxt;
  logic               r_valid, w_valid_nxt;

  logic [ID_W-1:0] w_max_hard, w_cnt_m1;
  logic [ID_W:0]   w_red_sum;
  logic            w_hard_zero, w_hard_cnt, w_hard_local, w_soft_local, w_free_scan;
  logic            w_ok, w_rx_beacon, w_upd, w_rescan;

  assign w_cnt_m1 = r_cnt - ID_W'(1);

  dplca_claim_decode #(
    .MAX_NODES (MAX_NODES),
    .ID_W      (ID_W)
  ) u_claim_decode (
    .txop_claim_table (txop_claim_table),
    .cnt_m1_idx       (w_cnt_m1),
    .local_idx        (r_local_id),
    .scan_idx         (r_scan_idx),
    .max_hard_claim   (w_max_hard),
    .hard_at_zero     (w_hard_zero),
    .hard_at_cnt_m1   (w_hard_cnt),
    .hard_at_local    (w_hard_local),
    .soft_at_local    (w_soft_local),
    .free_at_scan     (w_free_scan)
  );

  assign w_ok        = (plca_status == STATUS_OK);
  assign w_rx_beacon = (rx_cmd == CMD_BEACON);
  assign w_upd       = dplca_txop_table_upd && dplca_new_age && !w_rx_beacon && !w_hard_zero;
  assign w_red_sum   = {1'b0, w_max_hard} + (ID_W+1)'(2);
  assign w_rescan    = dplca_txop_table_upd && w_ok &&
                       (w_hard_local || w_soft_local ||
                        ((dplca_txop_id == '0) && (dplca_txop_node_count <= r_local_id)) ||
                        (dplca_new_age && (r_local_id > w_max_hard)));

`ifndef DPLCA_LOOPBACK_EN
  logic w_unused_lb;
  assign w_unused_lb = ^{tx_cmd, CRS, COL};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_local_id;
    w_cnt_nxt   = r_cnt;
    w_aging_nxt = r_aging;
    w_valid_nxt = r_valid;
    w_scan_nxt  = r_scan_idx;
    if (!dplca_en || !plca_en) begin
      w_state_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED: w_state_nxt = ST_WAIT_BEACON;
        ST_WAIT_BEACON: begin
          if (w_ok)               w_state_nxt = ST_LEARNING;
          else if (r_tmr == '0)   w_state_nxt = coordinator_role_allowed ? ST_COORDINATOR : ST_DISABLED;
        end
        ST_COORDINATOR: begin
          if (w_upd && w_hard_cnt && (r_cnt < c_id_max))
            w_state_nxt = ST_INCREASE_NODE_COUNT;
          else if ((dplca_txop_table_upd && w_hard_zero) || (w_rx_beacon && !plca_tx_beacon))
            w_state_nxt = ST_LEARNING;
`ifdef DPLCA_LOOPBACK_EN
          else if (w_rx_beacon && plca_tx_beacon)
            w_state_nxt = ST_LOOPBACK;
`endif
          else if (plca_tx_beacon)
            w_state_nxt = ST_COORDINATOR;
          else if (w_upd && !w_hard_cnt && (r_cnt > c_cnt_min))
            w_state_nxt = ST_REDUCE_NODE_COUNT;
        end
        ST_REDUCE_NODE_COUNT, ST_INCREASE_NODE_COUNT: begin
          if (!dplca_new_age) w_state_nxt = ST_COORDINATOR;
        end
        ST_LEARNING: begin
          if (!w_ok)                                          w_state_nxt = ST_DISABLED;
          else if (dplca_txop_table_upd && dplca_new_age)     w_state_nxt = ST_FOLLOWER_SCAN;
        end
        ST_FOLLOWER_SCAN: begin
          // Abandoning the scan leaves the pre-scan ID/valid untouched.
          if (!w_ok) begin
            w_state_nxt = ST_DISABLED;
          end else if (w_free_scan) begin
            w_id_nxt    = r_scan_idx;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_FOLLOWER;
          end else if (r_scan_idx >= w_cnt_m1) begin
            w_id_nxt    = c_id_max;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_FOLLOWER;
          end else begin
            w_scan_nxt = r_scan_idx + ID_W'(1);
          end
        end
        ST_FOLLOWER: begin
          if (!w_ok)          w_state_nxt = ST_DISABLED;
          else if (w_rescan)  w_state_nxt = ST_FOLLOWER_SCAN;
        end
`ifdef DPLCA_LOOPBACK_EN
        ST_LOOPBACK: begin
          if ((tx_cmd != CMD_BEACON) && !w_rx_beacon && !CRS && !COL)
            w_state_nxt = ST_COORDINATOR;
        end
`endif
        default: w_state_nxt = ST_DISABLED;
      endcase
    end

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_DISABLED: w_aging_nxt = 1'b0;
        ST_WAIT_BEACON: begin
          w_id_nxt    = c_id_max;
          w_cnt_nxt   = c_cnt_min;
          w_valid_nxt = 1'b0;
        end
        ST_COORDINATOR: begin
          w_id_nxt    = '0;
          w_aging_nxt = 1'b1;
          w_valid_nxt = 1'b1;
        end
        ST_REDUCE_NODE_COUNT: begin
          if (w_red_sum < {1'b0, c_cnt_min})      w_cnt_nxt = c_cnt_min;
          else if (w_red_sum > {1'b0, c_id_max})  w_cnt_nxt = c_id_max;
          else                                    w_cnt_nxt = w_red_sum[ID_W-1:0];
        end
        ST_INCREASE_NODE_COUNT: begin
          w_cnt_nxt = (r_cnt == c_id_max) ? r_cnt : r_cnt + ID_W'(1);
        end
        ST_LEARNING: begin
          w_id_nxt    = c_id_max;
          w_valid_nxt = 1'b0;
          w_aging_nxt = 1'b1;
        end
        ST_FOLLOWER_SCAN: w_scan_nxt = ID_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (plca_reset) begin
      r_state    <= ST_DISABLED;
      r_tmr      <= c_tmr_load;
      r_local_id <= c_id_max;
      r_cnt      <= c_cnt_min;
      r_scan_idx <= ID_W'(1);
      r_aging    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_local_id <= w_id_nxt;
      r_cnt      <= w_cnt_nxt;
      r_scan_idx <= w_scan_nxt;
      r_aging    <= w_aging_nxt;
      r_valid    <= w_valid_nxt;
      if (r_state == ST_DISABLED)
        r_tmr <= c_tmr_load;
      else if ((r_state == ST_WAIT_BEACON) && (r_tmr != '0))
        r_tmr <= r_tmr - c_tmr_w'(1);
    end
  end

  assign local_nodeID    = r_local_id;
  assign plca_node_count = r_cnt;
  assign dplca_aging     = r_aging;
  assign node_id_valid   = r_valid;
  assign dplca_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dplca_node_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_dplca_node_ctrl
// Description : Self-checking bench for dplca_node_ctrl with a behavioural model.
// Revision    : 1.0
//----------------------------------------------------------------------------
module tb_dplca_node_ctrl;
  import dplca_pkg::*;

  localparam int MAX_NODES          = 256;
  localparam int ID_W               = 8;
  localparam int MIN_NODE_COUNT     = 8;
  localparam int WAIT_BEACON_CYCLES = 16;

  logic                   clk = 1'b0;
  logic                   plca_reset, dplca_en, plca_en, coordinator_role_allowed, plca_status;
  logic [1:0]             rx_cmd, tx_cmd;
  logic                   CRS, COL, plca_tx_beacon, dplca_txop_table_upd, dplca_new_age;
  logic [ID_W-1:0]        dplca_txop_id, dplca_txop_node_count;
  logic [2*MAX_NODES-1:0] tbl;
  logic [ID_W-1:0]        local_nodeID, plca_node_count;
  logic                   dplca_aging, node_id_valid;
  logic [3:0]             dplca_state;

  always #5 clk = ~clk;

  dplca_node_ctrl #(
    .MAX_NODES          (MAX_NODES),
    .ID_W               (ID_W),
    .MIN_NODE_COUNT     (MIN_NODE_COUNT),
    .WAIT_BEACON_CYCLES (WAIT_BEACON_CYCLES)
  ) dut (
    .clk                      (clk),
    .plca_reset               (plca_reset),
    .dplca_en                 (dplca_en),
    .plca_en                  (plca_en),
    .coordinator_role_allowed (coordinator_role_allowed),
    .plca_status              (plca_status),
    .rx_cmd                   (rx_cmd),
    .tx_cmd                   (tx_cmd),
    .CRS                      (CRS),
    .COL                      (COL),
    .plca_tx_beacon           (plca_tx_beacon),
    .dplca_txop_table_upd     (dplca_txop_table_upd),
    .dplca_new_age            (dplca_new_age),
    .dplca_txop_id            (dplca_txop_id),
    .dplca_txop_node_count    (dplca_txop_node_count),
    .txop_claim_table         (tbl),
    .local_nodeID             (local_nodeID),
    .plca_node_count          (plca_node_count),
    .dplca_aging              (dplca_aging),
    .node_id_valid            (node_id_valid),
    .dplca_state              (dplca_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the expected outputs after the next clock edge.
  dplca_state_e m_st;
  int           m_id, m_cnt, m_idx, m_wcnt;
  bit           m_aging, m_valid;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit t_hard(input int i);
    return tbl[2*i+1];
  endfunction

  function automatic int t_code(input int i);
    return int'(tbl[2*i +: 2]);
  endfunction

  function automatic int max_hard();
    for (int i = MAX_NODES-1; i > 0; i--) if (tbl[2*i+1]) return i;
    return 0;
  endfunction

  task automatic set_entry(input int i, input int code);
    tbl[2*i +: 2] = 2'(code);
  endtask

  task automatic m_enter(input dplca_state_e s);
    m_st = s;
    case (s)
      ST_DISABLED:    m_aging = 0;
      ST_WAIT_BEACON: begin m_id = MAX_NODES-1; m_cnt = MIN_NODE_COUNT; m_valid = 0; m_wcnt = 0; end
      ST_COORDINATOR: begin m_id = 0; m_aging = 1; m_valid = 1; end
      ST_LEARNING:    begin m_id = MAX_NODES-1; m_valid = 0; m_aging = 1; end
      ST_FOLLOWER_SCAN: m_idx = 1;
      default: ;
    endcase
  endtask

  task automatic model_next();
    bit ok, rxb, upd, h0, hc, resc;
    int mh, c;
    if (plca_reset) begin
      m_st = ST_DISABLED; m_id = MAX_NODES-1; m_cnt = MIN_NODE_COUNT; m_aging = 0; m_valid = 0;
      return;
    end
    if (!dplca_en || !plca_en) begin
      m_enter(ST_DISABLED);
      return;
    end
    ok  = plca_status;
    rxb = (rx_cmd == 2'b00);
    mh  = max_hard();
    h0  = t_hard(0);
    hc  = t_hard(m_cnt-1);
    upd = dplca_txop_table_upd && dplca_new_age && !rxb && !h0;
    case (m_st)
      ST_DISABLED: m_enter(ST_WAIT_BEACON);
      ST_WAIT_BEACON: begin
        m_wcnt++;
        if (ok) m_enter(ST_LEARNING);
        else if (m_wcnt >= WAIT_BEACON_CYCLES)
          m_enter(coordinator_role_allowed ? ST_COORDINATOR : ST_DISABLED);
      end
      ST_COORDINATOR: begin
        if (upd && hc && m_cnt < MAX_NODES-1) begin
          m_st = ST_INCREASE_NODE_COUNT;
          m_cnt = m_cnt + 1;
        end else if ((dplca_txop_table_upd && h0) || (rxb && !plca_tx_beacon)) begin
          m_enter(ST_LEARNING);
`ifdef DPLCA_LOOPBACK_EN
        end else if (rxb && plca_tx_beacon) begin
          m_st = ST_LOOPBACK;
`endif
        end else if (plca_tx_beacon) begin
          m_st = ST_COORDINATOR;
        end else if (upd && !hc && m_cnt > MIN_NODE_COUNT) begin
          c = mh + 2;
          if (c < MIN_NODE_COUNT) c = MIN_NODE_COUNT;
          if (c > MAX_NODES-1) c = MAX_NODES-1;
          m_cnt = c;
          m_st = ST_REDUCE_NODE_COUNT;
        end
      end
      ST_REDUCE_NODE_COUNT, ST_INCREASE_NODE_COUNT: if (!dplca_new_age) m_enter(ST_COORDINATOR);
      ST_LEARNING: begin
        if (!ok) m_enter(ST_DISABLED);
        else if (dplca_txop_table_upd && dplca_new_age) m_enter(ST_FOLLOWER_SCAN);
      end
      ST_FOLLOWER_SCAN: begin
        if (!ok) m_enter(ST_DISABLED);
        else if (t_code(m_idx) == 0) begin m_id = m_idx; m_valid = 1; m_st = ST_FOLLOWER; end
        else if (m_idx >= m_cnt-1) begin m_id = MAX_NODES-1; m_valid = 0; m_st = ST_FOLLOWER; end
        else m_idx++;
      end
      ST_FOLLOWER: begin
        resc = dplca_txop_table_upd && ok &&
               (t_hard(m_id) || t_code(m_id) == 1 ||
                (dplca_txop_id == 0 && int'(dplca_txop_node_count) <= m_id) ||
                (dplca_new_age && m_id > mh));
        if (!ok) m_enter(ST_DISABLED);
        else if (resc) m_enter(ST_FOLLOWER_SCAN);
      end
`ifdef DPLCA_LOOPBACK_EN
      ST_LOOPBACK: if (tx_cmd != 2'b00 && !rxb && !CRS && !COL) m_enter(ST_COORDINATOR);
`endif
      default: m_enter(ST_DISABLED);
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(dplca_state), int'(m_st));
    check("local_nodeID", int'(local_nodeID), m_id);
    check("node_count", int'(plca_node_count), m_cnt);
    check("aging", int'(dplca_aging), int'(m_aging));
    check("valid", int'(node_id_valid), int'(m_valid));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse_upd_age();
    dplca_txop_table_upd = 1; dplca_new_age = 1;
    step();
    dplca_txop_table_upd = 0; dplca_new_age = 0;
  endtask

  task automatic grow_to(input int n);
    for (int k = 0; k < 300 && m_cnt < n; k++) begin
      tbl = '0;
      set_entry(m_cnt-1, 2);
      pulse_upd_age();
      step();
    end
  endtask

  initial begin
    bit fail_mode;
    plca_reset = 1; dplca_en = 1; plca_en = 1; coordinator_role_allowed = 1; plca_status = 0;
    rx_cmd = 2'b10; tx_cmd = 2'b10; CRS = 0; COL = 0; plca_tx_beacon = 0;
    dplca_txop_table_upd = 0; dplca_new_age = 0; dplca_txop_id = 8'd1; dplca_txop_node_count = 8'd0;
    tbl = '0;
    step(); step();
    check("rst_state", int'(dplca_state), 0);
    check("rst_id", int'(local_nodeID), 255);
    check("rst_count", int'(plca_node_count), 8);
    check("rst_valid_aging", int'({node_id_valid, dplca_aging}), 0);

    // Wait-beacon timeout into COORDINATOR.
    plca_reset = 0;
    repeat (16) step();
    check("wait_boundary", int'(dplca_state), int'(ST_WAIT_BEACON));
    step();
    check("coord_state", int'(dplca_state), int'(ST_COORDINATOR));
    check("coord_id_aging", int'({local_nodeID, dplca_aging}), 1);

    // Increase on HARD(count-1).
    set_entry(7, 2);
    pulse_upd_age();
    check("increase_count", int'(plca_node_count), 9);
    check("increase_state", int'(dplca_state), int'(ST_INCREASE_NODE_COUNT));
    step();
    check("increase_exit", int'(dplca_state), int'(ST_COORDINATOR));

    // Reduce with clamp and without.
    grow_to(20);
    check("grow_count", int'(plca_node_count), 20);
    tbl = '0; set_entry(5, 2);
    pulse_upd_age();
    check("reduce_clamp", int'(plca_node_count), 8);
    step();
    grow_to(20);
    tbl = '0; set_entry(12, 2);
    pulse_upd_age();
    check("reduce_14", int'(plca_node_count), 14);
    step();
    tbl = '0; set_entry(8, 3);
    pulse_upd_age();
    check("reduce_10", int'(plca_node_count), 10);
    step();

    // Learning and follower scan.
    plca_status = 1; tbl = '0;
    rx_cmd = 2'b00; step(); rx_cmd = 2'b10;
    check("learning_state", int'(dplca_state), int'(ST_LEARNING));
    for (int i = 1; i <= 4; i++) set_entry(i, 2);
    pulse_upd_age();
    repeat (4) step();
    check("scan_running", int'(dplca_state), int'(ST_FOLLOWER_SCAN));
    step();
    check("scan_id5", int'(local_nodeID), 5);
    check("scan_valid5", int'({dplca_state, node_id_valid}), int'({ST_FOLLOWER, 1'b1}));
    set_entry(5, 1);
    dplca_txop_table_upd = 1; step(); dplca_txop_table_upd = 0;
    repeat (6) step();
    check("rescan_id6", int'(local_nodeID), 6);

    // Full table: no free ID, then disable mid-scan.
    for (int i = 1; i <= 9; i++) set_entry(i, 2);
    dplca_txop_table_upd = 1; step(); dplca_txop_table_upd = 0;
    repeat (9) step();
    check("full_id", int'(local_nodeID), 255);
    check("full_valid", int'(node_id_valid), 0);
    dplca_txop_id = 0;
    dplca_txop_table_upd = 1; step(); dplca_txop_table_upd = 0;
    dplca_txop_id = 8'd1;
    repeat (3) step();
    plca_en = 0; step(); plca_en = 1;
    check("abort_state", int'(dplca_state), int'(ST_DISABLED));
    check("abort_aging", int'(dplca_aging), 0);

    // Own beacon echo.
    plca_status = 0;
    repeat (17) step();
    check("coord_again", int'(dplca_state), int'(ST_COORDINATOR));
    rx_cmd = 2'b00; plca_tx_beacon = 1; step();
    rx_cmd = 2'b10; plca_tx_beacon = 0; CRS = 1;
    repeat (5) step();
`ifdef DPLCA_LOOPBACK_EN
    check("loopback_hold", int'(dplca_state), int'(ST_LOOPBACK));
`else
    check("no_loopback", int'(dplca_state), int'(ST_COORDINATOR));
`endif
    CRS = 0; step();
    check("loopback_exit", int'(dplca_state), int'(ST_COORDINATOR));

    // Randomized traffic against the model.
    fail_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) fail_mode = ($urandom_range(0, 2) == 0);
      plca_reset = ($urandom_range(0, 499) == 0);
      dplca_en   = ($urandom_range(0, 99) != 0);
      plca_en    = ($urandom_range(0, 99) != 0);
      plca_status = fail_mode ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 31) != 0);
      coordinator_role_allowed = ($urandom_range(0, 3) != 0);
      rx_cmd = 2'($urandom_range(0, 3));
      tx_cmd = 2'($urandom_range(0, 3));
      CRS = ($urandom_range(0, 3) == 0);
      COL = ($urandom_range(0, 7) == 0);
      plca_tx_beacon = ($urandom_range(0, 3) == 0);
      dplca_txop_table_upd = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) dplca_new_age = ~dplca_new_age;
      dplca_txop_id = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      dplca_txop_node_count = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 0) set_entry($urandom_range(1, 31), $urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) set_entry(0, $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) set_entry($urandom_range(0, 255), $urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) tbl = '0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
